// File: rtl/xgmii_pkg.sv
// Shared XGMII character codes, link-fault status encodings and fault-mode types
// used by the transmit fault responder and the frame tracker.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;

  localparam logic [1:0] LINK_FAULT_OK     = 2'd0;
  localparam logic [1:0] LINK_FAULT_LOCAL  = 2'd1;
  localparam logic [1:0] LINK_FAULT_REMOTE = 2'd2;

  typedef enum logic [1:0] {
    FM_PASS      = 2'd0,
    FM_SEND_RF   = 2'd1,
    FM_SEND_IDLE = 2'd2
  } fault_mode_e;

  // Remote Fault ordered set in both columns: Sequence control in lanes 0 and 4.
  localparam logic [63:0] RF_TXD = {8'h02, 8'h00, 8'h00, XGMII_SEQ,
                                    8'h02, 8'h00, 8'h00, XGMII_SEQ};
  localparam logic [7:0]  RF_TXC = 8'h11;

  localparam logic [63:0] IDLE_TXD = {8{XGMII_IDLE}};
  localparam logic [7:0]  IDLE_TXC = 8'hFF;

  // Local fault outranks remote fault when both are reported.
  function automatic logic [1:0] link_fault_status(input logic lf, input logic rf);
    if (lf)
      return LINK_FAULT_LOCAL;
    else if (rf)
      return LINK_FAULT_REMOTE;
    else
      return LINK_FAULT_OK;
  endfunction

endpackage

// File: rtl/xgmii_frame_tracker.sv
// Decodes START/TERMINATE on a 64-bit XGMII word and tracks whether the
// stream is inside a frame.
module xgmii_frame_tracker
  import xgmii_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic [63:0] txd,
  input  logic [7:0]  txc,
  output logic        start0,
  output logic        start4,
  output logic        term,
  output logic        in_frame_q
);

  logic [7:0] term_lane;
  logic       in_frame_next;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_term_lane
      assign term_lane[gi] = txc[gi] && (txd[8*gi +: 8] == XGMII_TERM);
    end
  endgenerate

  assign start0 = txc[0] && (txd[7:0]   == XGMII_START);
  assign start4 = txc[4] && (txd[39:32] == XGMII_START);
  assign term   = |term_lane;

  // A lane-4 START follows any TERM in the same word, so it wins.
  always_comb begin
    in_frame_next = in_frame_q;
    if (start4)
      in_frame_next = 1'b1;
    else if (term)
      in_frame_next = 1'b0;
    else if (start0)
      in_frame_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst)
      in_frame_q <= 1'b0;
    else
      in_frame_q <= in_frame_next;
  end

endmodule

// File: rtl/tx_fault_responder.sv
// Replaces XGMII transmit words with Remote Fault or Idle while link faults are
// reported, switching only between frames, with one cycle of latency.
module tx_fault_responder
  import xgmii_pkg::*;
#(
  parameter int MIN_HOLD_COLS = 4
) (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx,
  input  logic        status_local_fault_ctx,
  input  logic        status_remote_fault_ctx,
  input  logic [63:0] txd_in,
  input  logic [7:0]  txc_in,
  output logic [63:0] txd_out,
  output logic [7:0]  txc_out,
  output logic [1:0]  fault_mode,
  output logic        frame_dropped
);

  localparam logic [7:0] HOLD_LOAD = 8'(MIN_HOLD_COLS - 1);

  fault_mode_e mode_reg, mode_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic [63:0] txd_next;
  logic [7:0]  txc_next;
  logic        dropped_next;
  logic [1:0]  fault_status;

  logic start0, start4, in_frame_q, term_unused;

  xgmii_frame_tracker u_tracker (
    .clk        (clk_xgmii_tx),
    .srst       (reset_xgmii_tx),
    .txd        (txd_in),
    .txc        (txc_in),
    .start0     (start0),
    .start4     (start4),
    .term       (term_unused),
    .in_frame_q (in_frame_q)
  );

  assign fault_status = link_fault_status(status_local_fault_ctx, status_remote_fault_ctx);

  always_ff @(posedge clk_xgmii_tx) begin
    if (reset_xgmii_tx) begin
      mode_reg      <= FM_PASS;
      hold_cnt_reg  <= 8'd0;
      txd_out       <= IDLE_TXD;
      txc_out       <= IDLE_TXC;
      frame_dropped <= 1'b0;
    end else begin
      mode_reg      <= mode_next;
      hold_cnt_reg  <= hold_cnt_next;
      txd_out       <= txd_next;
      txc_out       <= txc_next;
      frame_dropped <= dropped_next;
    end
  end

  // Next mode and hysteresis counter for the word currently on the input.
  always_comb begin
    mode_next = mode_reg;
    if (mode_reg == FM_PASS) begin
      // A frame already on the output is allowed to complete.
      if (!in_frame_q) begin
        case (fault_status)
          LINK_FAULT_LOCAL:  mode_next = FM_SEND_RF;
          LINK_FAULT_REMOTE: mode_next = FM_SEND_IDLE;
          default:           mode_next = FM_PASS;
        endcase
      end
    end else begin
      case (fault_status)
        LINK_FAULT_LOCAL:  mode_next = FM_SEND_RF;
        LINK_FAULT_REMOTE: mode_next = FM_SEND_IDLE;
        default: begin
          if (hold_cnt_reg == 8'd0 && !in_frame_q && !start0 && !start4)
            mode_next = FM_PASS;
        end
      endcase
    end

    hold_cnt_next = 8'd0;
    if (mode_next != FM_PASS) begin
      if (fault_status != LINK_FAULT_OK)
        hold_cnt_next = HOLD_LOAD;
      else if (hold_cnt_reg != 8'd0)
        hold_cnt_next = hold_cnt_reg - 8'd1;
    end
  end

  // Output word selected by the decided mode.
  always_comb begin
    txd_next     = txd_in;
    txc_next     = txc_in;
    dropped_next = (mode_next != FM_PASS) && (start0 || start4);
    case (mode_next)
      FM_SEND_RF: begin
        txd_next = RF_TXD;
        txc_next = RF_TXC;
      end
      FM_SEND_IDLE: begin
        txd_next = IDLE_TXD;
        txc_next = IDLE_TXC;
      end
      default: begin
        txd_next = txd_in;
        txc_next = txc_in;
      end
    endcase
  end

  assign fault_mode = mode_reg;

endmodule

// File: tb/tb_tx_fault_responder.sv
// Random XGMII frame stream with toggling fault inputs and occasional resets,
// compared cycle by cycle against a behavioural model of the fault responder.
module tb_tx_fault_responder;

  localparam int HOLD = 4;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        lf_in, rf_in;
  logic [63:0] txd_in, txd_out;
  logic [7:0]  txc_in, txc_out;
  logic [1:0]  fault_mode;
  logic        frame_dropped;

  always #5 clk = ~clk;

  tx_fault_responder #(.MIN_HOLD_COLS(HOLD)) dut (
    .clk_xgmii_tx            (clk),
    .reset_xgmii_tx          (rst),
    .status_local_fault_ctx  (lf_in),
    .status_remote_fault_ctx (rf_in),
    .txd_in                  (txd_in),
    .txc_in                  (txc_in),
    .txd_out                 (txd_out),
    .txc_out                 (txc_out),
    .fault_mode              (fault_mode),
    .frame_dropped           (frame_dropped)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: integer mode (0 pass, 1 RF, 2 idle), frame flag, hold count.
  int          m_mode, m_hold;
  bit          m_in_frame;
  logic [63:0] e_txd;
  logic [7:0]  e_txc;
  int          e_mode;
  bit          e_drop;
  int          n_rf, n_idle, n_drop;

  task automatic model_reset();
    m_mode = 0; m_hold = 0; m_in_frame = 0;
    e_txd = 64'h0707070707070707; e_txc = 8'hFF; e_mode = 0; e_drop = 0;
  endtask

  task automatic model_step(input bit lf, input bit rf, input logic [63:0] d, input logic [7:0] c);
    bit s0, s4, tm;
    int nm;
    s0 = c[0] && d[7:0] == 8'hFB;
    s4 = c[4] && d[39:32] == 8'hFB;
    tm = 0;
    for (int i = 0; i < 8; i++)
      if (c[i] && d[8*i +: 8] == 8'hFD) tm = 1;
    if (lf && (m_mode != 0 || !m_in_frame))      nm = 1;
    else if (rf && (m_mode != 0 || !m_in_frame)) nm = 2;
    else if (m_mode == 0)                         nm = 0;
    else if (m_hold == 0 && !m_in_frame && !s0 && !s4) nm = 0;
    else                                          nm = m_mode;
    if (nm == 0)         m_hold = 0;
    else if (lf || rf)   m_hold = HOLD - 1;
    else if (m_hold > 0) m_hold = m_hold - 1;
    m_mode = nm;
    if (s4)      m_in_frame = 1;
    else if (tm) m_in_frame = 0;
    else if (s0) m_in_frame = 1;
    e_mode = nm;
    e_drop = (nm != 0) && (s0 || s4);
    if (nm == 1)      begin e_txd = 64'h0200009C0200009C; e_txc = 8'h11; n_rf++; end
    else if (nm == 2) begin e_txd = 64'h0707070707070707; e_txc = 8'hFF; n_idle++; end
    else              begin e_txd = d; e_txc = c; end
    if (e_drop) n_drop++;
  endtask

  // Upstream frame generator: gap of idles, START (lane 0 or 4), data, TERM.
  int g_state = 0, g_gap = 2, g_data = 0;

  task automatic gen_word(output logic [63:0] d, output logic [7:0] c);
    int k;
    d = 64'h0707070707070707; c = 8'hFF;
    if ($urandom_range(0, 24) == 0) begin
      d = {$urandom, $urandom}; c = 8'($urandom);
    end else if (g_state == 0) begin
      if (g_gap > 0) g_gap--;
      else begin
        if ($urandom_range(0, 1) == 0) begin
          d = {$urandom, $urandom}; c = 8'h01; d[7:0] = 8'hFB;
        end else begin
          d = {$urandom, $urandom}; c = 8'h1F;
          d[31:0] = 32'h07070707; d[39:32] = 8'hFB;
        end
        g_data = $urandom_range(0, 6); g_state = 1;
      end
    end else if (g_data > 0) begin
      d = {$urandom, $urandom}; c = 8'h00; g_data--;
    end else begin
      k = $urandom_range(0, 7);
      for (int i = 0; i < 8; i++) begin
        if (i < k)       begin d[8*i +: 8] = 8'($urandom); c[i] = 1'b0; end
        else if (i == k) begin d[8*i +: 8] = 8'hFD; c[i] = 1'b1; end
      end
      g_gap = $urandom_range(0, 5); g_state = 0;
    end
  endtask

  initial begin
    int phase_left;
    logic [63:0] d;
    logic [7:0]  c;
    n_rf = 0; n_idle = 0; n_drop = 0; phase_left = 0;
    rst = 1'b1; lf_in = 1'b0; rf_in = 1'b0;
    txd_in = 64'h0707070707070707; txc_in = 8'hFF;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_eq("txd_out", txd_out, e_txd);
      check_eq("txc_out", 64'(txc_out), 64'(e_txc));
      check_eq("fault_mode", 64'(fault_mode), 64'(e_mode));
      check_eq("frame_dropped", 64'(frame_dropped), 64'(e_drop));
      if (phase_left == 0) begin
        lf_in = ($urandom_range(0, 3) == 0);
        rf_in = ($urandom_range(0, 2) == 0);
        phase_left = $urandom_range(1, 20);
      end
      phase_left--;
      gen_word(d, c);
      txd_in = d; txc_in = c;
      if (cyc < 3 || $urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
        model_step(lf_in, rf_in, d, c);
      end
    end
    @(negedge clk);
    check_eq("txd_out", txd_out, e_txd);
    check_eq("fault_mode", 64'(fault_mode), 64'(e_mode));
    $display("info: rf_words=%0d idle_words=%0d dropped_starts=%0d", n_rf, n_idle, n_drop);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
